// File: rtl/dmem_bus_demux_if.sv
// Bus bundle for dmem_bus_demux: core request/response plus the RAM and I/O target ports.
// The demux uses the slave modport; the driving side (core and targets) uses master.
interface dmem_bus_demux_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic        io_valid;
    logic [31:0] io_addr;
    logic        io_we;
    logic [3:0]  io_wstrb;
    logic [31:0] io_wdata;
    logic        io_ack;
    logic [31:0] io_rdata;

    modport slave (
        input  req_valid, req_addr, req_we, req_wstrb, req_wdata,
        input  mem_ack, mem_rdata, io_ack, io_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        output io_valid, io_addr, io_we, io_wstrb, io_wdata
    );

    modport master (
        output req_valid, req_addr, req_we, req_wstrb, req_wdata,
        output mem_ack, mem_rdata, io_ack, io_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        input  io_valid, io_addr, io_we, io_wstrb, io_wdata
    );
endinterface

// File: rtl/dmem_bus_demux.sv
// Routes one data-memory request at a time to RAM or the I/O region and returns one response.
// Optional BUSY watchdog with error response is enabled by defining DMEM_BUS_TIMEOUT_EN.
module dmem_bus_demux #(
    parameter logic [31:0] IO_BASE        = 32'h0001_0000,
    parameter logic [31:0] IO_MASK        = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic             clk,
    input logic             rst,
    dmem_bus_demux_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        we_q, we_d;
    logic        sel_q, sel_d;
    logic        err_q, err_d;

    logic        req_is_io;
    logic        sel_ack;
    logic [31:0] sel_rdata;
    logic        timeout;

    assign req_is_io = (bus.req_addr & IO_MASK) == IO_BASE;
    // Acks from the target that was not selected never reach the FSM.
    assign sel_ack   = sel_q ? bus.io_ack : bus.mem_ack;
    assign sel_rdata = sel_q ? bus.io_rdata : bus.mem_rdata;

`ifdef DMEM_BUS_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter reads k during the (k+1)-th BUSY cycle, so the limit is hit on the last one.
    assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (state_q == StBusy && !sel_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        we_d    = we_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    wstrb_d = bus.req_wstrb;
                    we_d    = bus.req_we;
                    sel_d   = req_is_io;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // An ack on the limit cycle still completes normally.
                if (sel_ack) begin
                    rdata_d = we_q ? 32'h0 : sel_rdata;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (timeout) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.resp_valid = (state_q == StDone);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    assign bus.mem_valid  = (state_q == StBusy) && !sel_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_wstrb  = wstrb_q;
    assign bus.mem_wdata  = wdata_q;

    assign bus.io_valid   = (state_q == StBusy) && sel_q;
    assign bus.io_addr    = addr_q;
    assign bus.io_we      = we_q;
    assign bus.io_wstrb   = wstrb_q;
    assign bus.io_wdata   = wdata_q;

endmodule

// File: doc/dmem_bus_demux.md
Name: dmem_bus_demux

Overview:
- Splits the core's single data-memory request stream into two targets: data RAM (target 0) and the memory-mapped I/O region (target 1).
- Selects by address decode and holds each request until the selected target acknowledges.
- Returns one response to the core.
- Sits between the load/store path and the RAM/peripheral blocks in the FPGA test build.

Parameters:
- IO_BASE, 32'h0001_0000, base address of the I/O region.
- IO_MASK, 32'hFFFF_0000, mask applied to the address before comparing against IO_BASE.
- TIMEOUT_CYCLES, 16, number of BUSY cycles without an ack before an error response (only used with the optional feature).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  block can accept a request this cycle.
- req_addr  in  32  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_wstrb  in  4  byte enables for stores.
- req_wdata  in  32  store data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load data (0 for stores).
- resp_err  out  1  error flag, qualified by resp_valid.
- mem_valid, io_valid  out  1 each  request strobes to target 0 and target 1.
- mem_addr, io_addr  out  32 each  registered address.
- mem_we, io_we  out  1 each  registered write enable.
- mem_wstrb, io_wstrb  out  4 each  registered byte enables.
- mem_wdata, io_wdata  out  32 each  registered store data.
- mem_ack, io_ack  in  1 each  target completion pulse.
- mem_rdata, io_rdata  in  32 each  read data, valid with the matching ack.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values:
  - State = IDLE; req_ready = 1.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - Both *_valid = 0; all registered addr/we/wstrb/wdata = 0.
- IDLE:
  - req_ready = 1.
  - On req_valid: register addr, we, wstrb, wdata, and sel = ((req_addr & IO_MASK) == IO_BASE). Go to BUSY.
- BUSY:
  - req_ready = 0.
  - The selected target's *_valid = 1; the other target's valid = 0. The other target's outputs also hold the registered values.
  - Valid stays high until the selected target's ack is sampled high.
  - On that ack: latch the selected rdata (0 if we = 1), drop valid the same edge, go to DONE.
- DONE:
  - resp_valid = 1 for exactly one cycle; req_ready = 0. Then return to IDLE.
- Latency: request accepted at edge N, *_valid high in cycle N+1.
  - An ack in cycle N+1 gives resp_valid in cycle N+2.
  - Back-to-back throughput is one request per 3 cycles minimum.
- resp_rdata holds its value until the next DONE. resp_err = 0 unless the optional timeout fires.
- Boundary conditions:
  - An ack from the non-selected target is ignored in every state.
  - Any ack in IDLE or DONE is ignored.
  - req_valid while req_ready = 0 is not accepted; the core must hold the request.
  - An address exactly at IO_BASE, or anywhere in IO_BASE | ~IO_MASK, routes to I/O. All other addresses route to RAM.
  - No alignment checking is done here.
  - rst asserted in any state (including mid-BUSY): the next edge forces the reset values. The outstanding transaction is dropped with no resp_valid, and the target's valid falls on that edge.

Optional Feature:
- Macro: DMEM_BUS_TIMEOUT_EN.
- Defined:
  - A counter clears on BUSY entry and increments each BUSY cycle without the selected ack.
  - After TIMEOUT_CYCLES BUSY cycles with no ack: drop *_valid, go to DONE with resp_err = 1 and resp_rdata = 0.
  - An ack arriving on the same cycle the limit is reached wins: normal response, resp_err = 0.
- Undefined: no counter is built; BUSY waits indefinitely; resp_err is tied to 0.

Test Plan:
- Reset check: hold rst 2 cycles, then release. All outputs = 0 except req_ready = 1. Then assert rst mid-BUSY → next cycle mem_valid = 0, req_ready = 1, and no resp_valid ever appears.
- RAM load: req addr 0x0000_0040, we = 0. mem_ack in the first mem_valid cycle with mem_rdata 0x1234_5678 → resp_valid exactly 2 cycles after acceptance, resp_rdata = 0x1234_5678, resp_err = 0, io_valid never high.
- I/O store: addr 0x0001_0004, wdata 0x0000_00A5, wstrb 4'b0001. io_ack 3 cycles after io_valid → io_addr = 0x0001_0004, io_we = 1, io_wstrb = 0001, io_valid high 4 cycles, resp_valid 1 cycle later with resp_rdata = 0.
- Stray ack: during a RAM load, pulse io_ack with io_rdata 0xFFFF_FFFF; mem_ack 2 cycles later with mem_rdata 0x0000_0007 → transaction stays open until mem_ack, resp_rdata = 0x0000_0007.
- Back-to-back: req_valid held high for two loads (0x0000_0000 then 0x0001_0000) → second accepted only in the IDLE cycle after DONE. The second routes to io_valid.
- Timeout (macro defined): load to 0x0000_0100 with mem_ack never asserted → mem_valid high 16 cycles, then resp_valid with resp_err = 1 and resp_rdata = 0. Same stimulus with the macro undefined → mem_valid stays high and no response appears.
